// File: rtl/poly_tone_synth.sv
// Multi-key square-wave tone generator: per-key phase accumulators, mono priority or poly delta-sigma mix.
// Optional input debounce is enabled by defining DEBOUNCE_EN.
module poly_tone_synth #(
    parameter int                        NUM_KEYS  = 4,
    parameter int                        ACC_W     = 32,
    parameter logic [NUM_KEYS*ACC_W-1:0] INC_INIT  = {32'd37796, 32'd33673, 32'd28312, 32'd22471},
    parameter int                        DB_CYCLES = 65536,
    parameter int                        LVL_W     = $clog2(NUM_KEYS + 1),
    parameter int                        IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_n,
    input  logic                mode,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [NUM_KEYS-1:0] active,
    output logic [LVL_W-1:0]    level,
    output logic                q
);

    localparam int SUM_W = LVL_W + 1;

    logic [NUM_KEYS-1:0] sync1, sync2;
    logic [NUM_KEYS-1:0] kp;
    logic [ACC_W-1:0]    acc [NUM_KEYS];
    logic [ACC_W-1:0]    inc [NUM_KEYS];
    logic [NUM_KEYS-1:0] msb;
    logic [LVL_W-1:0]    sd_acc, sd_next, lvl_next;
    logic [SUM_W-1:0]    s;
    logic                poly_hit, mono_next, found, mode_q;

    // The synchroniser carries the pressed level, so its reset value means "released".
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~keys_n;
            sync2 <= sync1;
        end
    end

    assign kp = sync2;

`ifdef DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt [NUM_KEYS];

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (kp[i] == active[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    active[i] <= kp[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) active <= '0;
        else       active <= kp;
    end
`endif

    // Out-of-range indices match no key, so such writes fall through harmlessly.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
                acc[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) inc[i] <= cfg_inc;
                acc[i] <= active[i] ? acc[i] + inc[i] : '0;
            end
        end
    end

    always_comb begin
        lvl_next  = '0;
        mono_next = 1'b0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            msb[i] = acc[i][ACC_W-1];
            if (active[i] && msb[i]) lvl_next = lvl_next + LVL_W'(1);
            if (!found && active[i]) begin
                mono_next = msb[i];
                found     = 1'b1;
            end
        end

        s        = {1'b0, sd_acc} + {1'b0, level};
        poly_hit = (s >= SUM_W'(NUM_KEYS));
        sd_next  = sd_acc;
        if (mode) sd_next = poly_hit ? LVL_W'(s - SUM_W'(NUM_KEYS)) : LVL_W'(s);
        if (mode != mode_q) sd_next = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level  <= '0;
            q      <= 1'b0;
            sd_acc <= '0;
            mode_q <= 1'b0;
        end else begin
            level  <= lvl_next;
            q      <= mode ? poly_hit : mono_next;
            sd_acc <= sd_next;
            mode_q <= mode;
        end
    end

endmodule

// File: tb/tb_poly_tone_synth.sv
// Directed bench for poly_tone_synth (NUM_KEYS=4, ACC_W=8, DB_CYCLES=4); debounce checks need DEBOUNCE_EN.
module tb_poly_tone_synth;

    localparam int NK  = 4;
    localparam int AW  = 8;
    localparam int DB  = 4;
    localparam int IW  = 3;
`ifdef DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 3;
`endif
    localparam int D   = LAT - 3;

    logic          clk;
    logic          reset;
    logic [NK-1:0] keys_n;
    logic          mode;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_inc;
    logic [NK-1:0] active;
    logic [2:0]    level;
    logic          q;

    int n_checks = 0;
    int n_fail   = 0;

    poly_tone_synth #(
        .NUM_KEYS (NK),
        .ACC_W    (AW),
        .INC_INIT ({8'd16, 8'd16, 8'd64, 8'd16}),
        .DB_CYCLES(DB),
        .IDX_W    (IW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .keys_n (keys_n),
        .mode   (mode),
        .cfg_we (cfg_we),
        .cfg_idx(cfg_idx),
        .cfg_inc(cfg_inc),
        .active (active),
        .level  (level),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic settle();
        keys_n = '1;
        cfg_we = 1'b0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    initial begin
        int  kk;
        bit  eq;
        reset   = 1'b1;
        keys_n  = '0;
        mode    = 1'b0;
        cfg_we  = 1'b0;
        cfg_idx = '0;
        cfg_inc = '0;

        // 1: reset state, then all keys held through release
        repeat (3) @(negedge clk);
        check("rst active", 32'(active), 32'd0);
        check("rst level", 32'(level), 32'd0);
        check("rst q", 32'(q), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == LAT - 1) check("rel active early", 32'(active), 32'd0);
            if (k == LAT)     check("rel active", 32'(active), 32'hF);
        end
        settle();

        // 2: mono, key0 alone with inc 32 -> period 8
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_inc = 8'd32; keys_n = 4'b1110;
        for (int k = 1; k <= 16 + LAT; k++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            kk = k - D;
            eq = (kk >= 4) && (((kk - 4) / 4) % 2 == 1);
            if (k == LAT - 1) check("t2 active early", 32'(active[0]), 32'd0);
            if (k == LAT)     check("t2 active", 32'(active[0]), 32'd1);
            check("t2 q", 32'(q), 32'(eq));
            check("t2 level", 32'(level), 32'(eq));
        end
        settle();

        // 3: mono priority key0 over key2, then hand-over to key2 on release
        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_inc = 8'd64; keys_n = 4'b1010;
        for (int k = 1; k <= 19 + LAT; k++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            kk = k - D;
            if (kk < 4)        eq = 1'b0;
            else if (kk <= 14) eq = (((kk - 4) / 4) % 2 == 1);
            else               eq = (((kk - 4) % 4) >= 2);
            check("t3 q", 32'(q), 32'(eq));
            if (k == 11) keys_n[0] = 1'b1;
        end
        settle();

        // 4: poly mix of keys 0 and 1 at the same pitch
        mode = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd1; cfg_inc = 8'd32; keys_n = 4'b1100;
        for (int k = 1; k <= 17 + LAT; k++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            kk = k - D;
            eq = (kk >= 9) && (((kk - 9) % 8) < 4) && (((kk - 9) % 2) == 1);
            check("t4 q", 32'(q), 32'(eq));
            check("t4 level", 32'((kk >= 4 && ((kk - 4) / 4) % 2 == 1) ? 2 : 0), 32'(level));
        end
        mode = 1'b0;
        settle();

        // 5: out-of-range write ignored, mid-note reset, write during reset ignored
        cfg_we = 1'b1; cfg_idx = 3'd5; cfg_inc = 8'd128; keys_n = 4'b1101;
        for (int k = 1; k <= 6 + LAT; k++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            kk = k - D;
            eq = (kk >= 4) && (((kk - 4) / 4) % 2 == 1);
            check("t5 q", 32'(q), 32'(eq));
        end
        reset = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd1; cfg_inc = 8'd128;
        @(negedge clk);
        check("midrst q", 32'(q), 32'd0);
        check("midrst active", 32'(active), 32'd0);
        check("midrst level", 32'(level), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0; cfg_we = 1'b0;
        for (int k = 1; k <= 9 + LAT; k++) begin
            @(negedge clk);
            kk = k - D;
            eq = (kk >= 4) && (((kk - 4) % 4) >= 2);
            check("t5 init q", 32'(q), 32'(eq));
        end
        settle();

`ifdef DEBOUNCE_EN
        // 6: short glitch rejected, sustained press accepted
        keys_n[1] = 1'b0;
        repeat (2) @(negedge clk);
        keys_n[1] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("glitch active1", 32'(active[1]), 32'd0);
        end
        keys_n[1] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) check("db active1 early", 32'(active[1]), 32'd0);
            if (k == 6) check("db active1", 32'(active[1]), 32'd1);
        end
        settle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
